// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: loader > starved fetch > data > fetch, ld_lock fences out data/fetch.
// Grant and memory command are same-cycle combinational; read data returns one cycle later; losers hold req.
module mem_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_lock,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DW-1:0]     ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AW-1:0]     d_addr,
  input  logic [DW-1:0]     d_wdata,
  input  logic [DW/8-1:0]   d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  input  logic              f_req,
  input  logic [AW-1:0]     f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DW-1:0]     rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_wstrb,
  input  logic [DW-1:0]     mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_LD, OWN_D, OWN_F} owner_t;

  owner_t     owner;
  logic [3:0] starve_cnt;
  logic       f_starved;
  logic       arb_open;

  // Loader always wins; while the loader phase is active nobody else may touch memory.
  assign f_starved = f_req && (starve_cnt == 4'(STARVE_LIMIT));
  assign arb_open  = !ld_req && !ld_lock;
  assign ld_gnt    = ld_req;
  assign f_gnt     = arb_open && f_req && (f_starved || !d_req);
  assign d_gnt     = arb_open && d_req && !f_starved;
  assign mem_en    = ld_gnt | d_gnt | f_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = f_addr;
    mem_wdata = '0;
    mem_wstrb = '1;
    if (ld_gnt) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      if (d_we) mem_wstrb = d_wstrb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      if (ld_gnt && !ld_we)     owner <= OWN_LD;
      else if (d_gnt && !d_we)  owner <= OWN_D;
      else if (f_gnt)           owner <= OWN_F;
      else                      owner <= OWN_NONE;

      // Saturates at the limit so a loader-blocked fetch keeps its claim.
      if (f_req && !f_gnt) begin
        if (starve_cnt != 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  assign ld_rvalid = (owner == OWN_LD);
  assign d_rvalid  = (owner == OWN_D);
  assign f_rvalid  = (owner == OWN_F);
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory stand-in, behavioural reference model, directed and random traffic.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic ld_lock, ld_req, ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic ld_gnt, ld_rvalid;
  logic d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0] d_wstrb;
  logic d_gnt, d_rvalid;
  logic f_req;
  logic [AW-1:0] f_addr;
  logic f_gnt, f_rvalid;
  logic [DW-1:0] rdata;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0] mem_wstrb;
  logic [DW-1:0] mem_rdata = '0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .ld_lock(ld_lock),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  // Memory array the arbiter drives.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected memory image, fetch-wait count, outstanding read owner (0 none,1 ld,2 d,3 f).
  logic [DW-1:0] shadow [2**AW];
  int            m_cnt  = 0;
  int            m_own  = 0;
  logic [DW-1:0] m_data = '0;

  always @(negedge clk) begin
    int            win;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [3:0]    ws;
    if (rst) begin
      m_cnt = 0;
      m_own = 0;
    end
    chk("ld_rvalid", ld_rvalid, m_own == 1);
    chk("d_rvalid", d_rvalid, m_own == 2);
    chk("f_rvalid", f_rvalid, m_own == 3);
    if (m_own != 0) chk("rdata", rdata, m_data);

    win = 0;
    if (ld_req) win = 1;
    else if (!ld_lock) begin
      if (f_req && m_cnt == SL) win = 3;
      else if (d_req)           win = 2;
      else if (f_req)           win = 3;
    end
    chk("ld_gnt", ld_gnt, win == 1);
    chk("d_gnt", d_gnt, win == 2);
    chk("f_gnt", f_gnt, win == 3);
    chk("mem_en", mem_en, win != 0);

    we = 1'b0; a = f_addr; wd = '0; ws = 4'hF;
    if (win == 1) begin we = ld_we; a = ld_addr; wd = ld_wdata; end
    if (win == 2) begin we = d_we;  a = d_addr;  wd = d_wdata; if (d_we) ws = d_wstrb; end
    if (win != 0) begin
      chk("mem_we", mem_we, we);
      chk("mem_addr", mem_addr, a);
      chk("mem_wstrb", mem_wstrb, ws);
      if (we) chk("mem_wdata", mem_wdata, wd);
    end

    // Memory contents change even while the arbiter is in reset.
    if (win != 0 && we)
      for (int b = 0; b < 4; b++) if (ws[b]) shadow[a][8*b +: 8] = wd[8*b +: 8];
    if (!rst) begin
      m_own  = (win != 0 && !we) ? win : 0;
      m_data = shadow[a];
      if (f_req && win != 3) m_cnt = (m_cnt < SL) ? m_cnt + 1 : SL;
      else                   m_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_one(input int who, input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
    logic g, rv;
    case (who)
      1: begin ld_req = 1'b1; ld_we = 1'b0; ld_addr = a; end
      2: begin d_req = 1'b1; d_we = 1'b0; d_addr = a; end
      default: begin f_req = 1'b1; f_addr = a; end
    endcase
    @(negedge clk);
    g = (who == 1) ? ld_gnt : (who == 2) ? d_gnt : f_gnt;
    chk({nm, "_gnt"}, g, 1'b1);
    tick();
    ld_req = 1'b0; d_req = 1'b0; f_req = 1'b0;
    @(negedge clk);
    rv = (who == 1) ? ld_rvalid : (who == 2) ? d_rvalid : f_rvalid;
    chk({nm, "_rvalid"}, rv, 1'b1);
    chk({nm, "_rdata"}, rdata, exp);
    tick();
  endtask

  task automatic ld_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = a; ld_wdata = v;
    tick();
    ld_req = 1'b0; ld_we = 1'b0;
  endtask

  logic [11:0] pat6;
  logic [9:0]  pat5;
  logic gl, gd, gf;

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]    = 32'hA500_0000 | i;
      shadow[i] = 32'hA500_0000 | i;
    end
    ld_lock = 0; ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    f_req = 0; f_addr = '0;

    // Reset with no requests.
    repeat (2) tick();
    @(negedge clk);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_gnts", {ld_gnt, d_gnt, f_gnt}, 3'b000);
    chk("rst_rvalids", {ld_rvalid, d_rvalid, f_rvalid}, 3'b000);
    tick();
    rst = 1'b0;
    tick();

    // Loader boot: data and fetch shut out for the whole phase.
    ld_lock = 1'b1;
    d_req = 1'b1; d_addr = 10'h005; f_req = 1'b1; f_addr = 10'h006;
    for (int i = 0; i < 4; i++) begin
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = AW'(i); ld_wdata = 32'h0000_0013;
      @(negedge clk);
      chk("boot_gnts", {ld_gnt, d_gnt, f_gnt}, 3'b100);
      tick();
    end
    ld_req = 1'b0; ld_we = 1'b0;
    @(negedge clk);
    chk("lock_idle_gnts", {ld_gnt, d_gnt, f_gnt}, 3'b000);
    tick();
    ld_lock = 1'b0; d_req = 1'b0; f_req = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) read_one(3, AW'(i), 32'h0000_0013, "boot_rd");

    // One isolated read per requester.
    ld_write(10'h010, 32'hCAFE_0010);
    read_one(3, 10'h010, 32'hCAFE_0010, "f_single");
    read_one(2, 10'h010, 32'hCAFE_0010, "d_single");
    read_one(1, 10'h010, 32'hCAFE_0010, "ld_single");

    // Data beats fetch until fetch has waited the limit, then fetch gets exactly one grant.
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020; f_req = 1'b1; f_addr = 10'h021;
    pat6 = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat6 = {pat6[9:0], d_gnt ? 2'd2 : f_gnt ? 2'd3 : 2'd0};
      tick();
    end
    chk("prio_pattern", pat6, 12'b10_10_10_10_11_10);
    d_req = 1'b0; f_req = 1'b0;
    tick();

    // Byte-lane write.
    ld_write(10'h030, 32'h1122_3344);
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h030; d_wdata = 32'h0000_AB00; d_wstrb = 4'b0010;
    @(negedge clk);
    chk("bytewr_gnt", d_gnt, 1'b1);
    tick();
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("write_no_rvalid", {ld_rvalid, d_rvalid, f_rvalid}, 3'b000);
    tick();
    read_one(2, 10'h030, 32'h1122_AB44, "bytewr_rd");

    // Back-to-back reads from different requesters.
    d_req = 1'b1; d_addr = 10'h040;
    @(negedge clk);
    chk("il_d_gnt", d_gnt, 1'b1);
    tick();
    d_req = 1'b0; f_req = 1'b1; f_addr = 10'h041;
    @(negedge clk);
    chk("il_n1_rvalids", {d_rvalid, f_rvalid}, 2'b10);
    chk("il_n1_rdata", rdata, 32'hA500_0040);
    chk("il_f_gnt", f_gnt, 1'b1);
    tick();
    f_req = 1'b0;
    @(negedge clk);
    chk("il_n2_rvalids", {d_rvalid, f_rvalid}, 2'b01);
    chk("il_n2_rdata", rdata, 32'hA500_0041);
    tick();

    // Reset lands on an outstanding fetch read: the read data must never surface.
    f_req = 1'b1; f_addr = 10'h050;
    @(negedge clk);
    chk("rst_rd_gnt", f_gnt, 1'b1);
    tick();
    f_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_rd_dropped", f_rvalid, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalids", {ld_rvalid, d_rvalid, f_rvalid}, 3'b000);
    chk("post_rst_gnts", {ld_gnt, d_gnt, f_gnt}, 3'b000);
    tick();

    // Partial wait count before reset must not survive it.
    d_req = 1'b1; d_addr = 10'h060; f_req = 1'b1; f_addr = 10'h061;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    pat5 = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pat5 = {pat5[7:0], d_gnt ? 2'd2 : f_gnt ? 2'd3 : 2'd0};
      tick();
    end
    chk("post_rst_prio", pat5, 10'b10_10_10_10_11);
    d_req = 1'b0; f_req = 1'b0;
    tick();

    // Random traffic; each requester holds its request until granted.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      gl = ld_gnt; gd = d_gnt; gf = f_gnt;
      tick();
      if (!ld_req || gl) begin
        ld_req = ($urandom_range(0, 9) == 0);
        ld_we = 1'($urandom); ld_addr = AW'($urandom_range(0, 63)); ld_wdata = $urandom;
      end
      if (!d_req || gd) begin
        d_req = ($urandom_range(0, 9) < 7);
        d_we = 1'($urandom); d_addr = AW'($urandom_range(0, 63));
        d_wdata = $urandom; d_wstrb = 4'($urandom);
      end
      if (!f_req || gf) begin
        f_req = ($urandom_range(0, 9) < 7);
        f_addr = AW'($urandom_range(0, 63));
      end
      ld_lock = ($urandom_range(0, 15) == 0);
    end
    ld_req = 1'b0; d_req = 1'b0; f_req = 1'b0; ld_lock = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's single-port unified memory between three requesters: the hex/program loader, the data (load/store) port, and the instruction-fetch port. Sits between the pipeline and the memory array; it issues at most one memory command per cycle and routes the one-cycle-late read data back to the requester that issued the read. Fixed priority with an anti-starvation override for fetch keeps the core progressing under heavy load/store traffic.

## Interface
- AW, 16, word address width (memory depth 2^AW words)
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch overrides data; legal range 1..15

- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- ld_lock  input  1  loader phase; while high only the loader may be granted
- ld_req / ld_we  input  1 / 1  loader request / write (1) or read (0)
- ld_addr / ld_wdata  input  AW / DW  loader address / write data (full-word writes)
- ld_gnt / ld_rvalid  output  1 / 1  loader grant / read data valid
- d_req / d_we  input  1 / 1  data-port request / write
- d_addr / d_wdata / d_wstrb  input  AW / DW / DW/8  data address / write data / byte enables
- d_gnt / d_rvalid  output  1 / 1  data grant / read data valid
- f_req / f_addr  input  1 / AW  fetch request (read-only) / address
- f_gnt / f_rvalid  output  1 / 1  fetch grant / read data valid
- rdata  output  DW  shared read data, qualified by the *_rvalid strobes
- mem_en / mem_we  output  1 / 1  memory command enable / write
- mem_addr / mem_wdata / mem_wstrb  output  AW / DW / DW/8  memory command fields
- mem_rdata  input  DW  memory read data, valid one cycle after a read command

## Operation
- Requester holds req and its fields stable until it sees gnt high on a rising edge; gnt and mem_* are combinational from current req/state, command is accepted that cycle.
- Winner selection per cycle, first match wins: (1) ld_req; (2) if ld_lock high, nothing else; (3) f_req if starve count == STARVE_LIMIT; (4) d_req; (5) f_req.
- Exactly one gnt high when any eligible req high; none otherwise. mem_en = OR of gnts.
- mem_wstrb: loader writes all ones; data port passes d_wstrb; fetch/reads drive all ones with mem_we=0.
- Starvation counter (4 bits): increments (saturating at STARVE_LIMIT) on each cycle f_req high and f_gnt low; clears when f_gnt high or f_req low. Loader-caused denials also count.
- Read routing: registered owner field (none/ld/d/f) captures the winner of each read command; next cycle exactly the owner's rvalid pulses for one cycle, rdata = mem_rdata. Writes produce no rvalid.
- Back-to-back reads from different requesters are legal; each rvalid follows its own grant by one cycle.

## Timing
- Grant latency: 0 cycles from req when winning; read data latency: 1 cycle after grant edge.
- Reset values: all *_rvalid 0, owner none, starve count 0; gnt/mem_* combinational (mem_en=0 when no req).
- Reset asserted mid-read: pending rvalid is dropped, never delivered after reset release.
- ld_lock change takes effect the same cycle (combinational into arbitration).
- Simultaneous all-three req, count < limit: loader wins; count at limit with no loader: fetch wins, data waits.
- Fetch override lasts one grant; counter then clears, data regains priority next cycle.

## Test plan
- Reset: assert rst mid-stream with an outstanding fetch read -> no rvalid after release; count 0; all gnt 0 with no req.
- Loader boot: ld_lock=1, ld writes 0x00000013 to addr 0x0000..0x0003, d_req/f_req held high -> only ld_gnt for 4 cycles, memory holds values, no d_gnt/f_gnt.
- Single read each: f_req addr 0x0010 alone -> f_gnt cycle N, f_rvalid cycle N+1 with rdata = mem[0x0010]; repeat for d and ld.
- Priority: d_req and f_req together, count reset, STARVE_LIMIT=4 -> d_gnt 4 cycles, f_gnt on cycle 5, d_gnt on cycle 6.
- Byte write: d_we=1, d_wstrb=4'b0010, d_wdata=0x0000AB00 to word holding 0x11223344 -> readback 0x1122AB44.
- Interleave: d read cycle N, f read cycle N+1 -> d_rvalid N+1, f_rvalid N+2, each with its own address's data, never both high.
